// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory controller: FSM state encoding and
// memory-mapped I/O register addresses.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_decode.sv
// MMIO decode for the LC-3 keyboard/display registers: address hit, read
// data mux, and the registered kbd_ack / dsp_valid pulses and display char.
module lc3_mmio_decode
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] addr_i,
  input  logic              start_i,
  input  logic              rw_i,
  input  logic [7:0]        wdata_i,
  input  logic [7:0]        kbd_data_i,
  input  logic              kbd_valid_i,
  input  logic              dsp_ready_i,
  output logic              hit_o,
  output logic              rd_upd_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              kbd_ack_o,
  output logic [7:0]        dsp_data_o,
  output logic              dsp_valid_o
);

  logic       is_kbsr, is_kbdr, is_dsr, is_ddr;
  logic       kbd_ack_q, dsp_valid_q;
  logic [7:0] dsp_data_q;

  assign is_kbsr = (addr_i == DATA_W'(KBSR_A));
  assign is_kbdr = (addr_i == DATA_W'(KBDR_A));
  assign is_dsr  = (addr_i == DATA_W'(DSR_A));
  assign is_ddr  = (addr_i == DATA_W'(DDR_A));

  assign hit_o    = is_kbsr | is_kbdr | is_dsr | is_ddr;
  // DDR is write-only, so a read of it leaves MDR alone
  assign rd_upd_o = hit_o & ~rw_i & ~is_ddr;

  // Read data for the status/data registers
  always_comb begin
    rdata_o = '0;
    if (is_kbsr)      rdata_o[DATA_W-1] = kbd_valid_i;
    else if (is_kbdr) rdata_o[7:0]      = kbd_data_i;
    else if (is_dsr)  rdata_o[DATA_W-1] = dsp_ready_i;
  end

  // One-cycle handshake pulses and the display character register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_ack_q   <= 1'b0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= '0;
    end else begin
      kbd_ack_q   <= start_i & ~rw_i & is_kbdr;
      dsp_valid_q <= start_i & rw_i & is_ddr;
      if (start_i && rw_i && is_ddr) dsp_data_q <= wdata_i;
    end
  end

  assign kbd_ack_o   = kbd_ack_q;
  assign dsp_valid_o = dsp_valid_q;
  assign dsp_data_o  = dsp_data_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR plus a one-access-per-request FSM against a
// req/ack memory port, raising R (ready) when the access ends. Accesses that
// see no ack within MAX_WAIT cycles abort with a sticky mem_err.
// Define LC3_MMIO_EN to decode the keyboard/display registers at FE00-FE06.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] mar_in,
  input  logic [DATA_W-1:0] mdr_in,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              err_clr,
  output logic [DATA_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ready,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [7:0]        kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ack,
  input  logic              dsp_ready,
  output logic [7:0]        dsp_data,
  output logic              dsp_valid
);

  localparam int unsigned     CW      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mar_q, mar_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic              rw_q, rw_d, req_q, req_d, we_q, we_d, err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              mmio_hit, mmio_rd_upd;
  logic [DATA_W-1:0] mmio_rdata;

`ifdef LC3_MMIO_EN
  logic mmio_start;
  assign mmio_start = (state_q == ST_IDLE) && mio_en;

  lc3_mmio_decode #(.DATA_W(DATA_W)) u_mmio (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (mar_q),
    .start_i     (mmio_start),
    .rw_i        (r_w),
    .wdata_i     (mdr_q[7:0]),
    .kbd_data_i  (kbd_data),
    .kbd_valid_i (kbd_valid),
    .dsp_ready_i (dsp_ready),
    .hit_o       (mmio_hit),
    .rd_upd_o    (mmio_rd_upd),
    .rdata_o     (mmio_rdata),
    .kbd_ack_o   (kbd_ack),
    .dsp_data_o  (dsp_data),
    .dsp_valid_o (dsp_valid)
  );
`else
  assign mmio_hit    = 1'b0;
  assign mmio_rd_upd = 1'b0;
  assign mmio_rdata  = '0;
  assign kbd_ack     = 1'b0;
  assign dsp_data    = '0;
  assign dsp_valid   = 1'b0;
  logic unused_mmio;
  assign unused_mmio = ^{kbd_data, kbd_valid, dsp_ready};
`endif

  // Next-state, register loads and memory-port updates
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    req_d   = req_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    // Clear first so a timeout on the same cycle still sets the flag
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_mar) mar_d = mar_in;
        if (ld_mdr) mdr_d = mdr_in;
        if (mio_en) begin
          rw_d = r_w;
          if (mmio_hit) begin
            if (mmio_rd_upd) mdr_d = mmio_rdata;
            state_d = ST_DONE;
          end else begin
            // Old MAR/MDR are issued even if a load happens this cycle
            req_d   = 1'b1;
            we_d    = r_w;
            addr_d  = mar_q;
            wdata_d = mdr_q;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          if (!rw_q) mdr_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
          if (!rw_q) mdr_d = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (ld_mar) mar_d = mar_in;
        if (ld_mdr) mdr_d = mdr_in;
        if (!mio_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      req_q   <= req_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign ready     = (state_q == ST_DONE);
  assign mem_err   = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Testbench for lc3_mem_ctrl: directed accesses with a scoreboard of expected
// MDR / mem_err values checked whenever ready rises.
module tb_lc3_mem_ctrl;

  logic        clk, rst_n;
  logic        ld_mar, ld_mdr, mio_en, r_w, err_clr;
  logic [15:0] mar_in, mdr_in, mar_out, mdr_out;
  logic        ready, mem_err, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  kbd_data, dsp_data;
  logic        kbd_valid, kbd_ack, dsp_ready, dsp_valid;

  lc3_mem_ctrl #(.DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mar_in(mar_in), .mdr_in(mdr_in), .mio_en(mio_en), .r_w(r_w),
    .err_clr(err_clr), .mar_out(mar_out), .mdr_out(mdr_out), .ready(ready),
    .mem_err(mem_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .kbd_ack(kbd_ack), .dsp_ready(dsp_ready), .dsp_data(dsp_data),
    .dsp_valid(dsp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] mdr;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Memory responder / bus observation state
  int          ack_after = 0;
  logic [15:0] rd_val    = '0;
  logic        resp_en   = 1'b1;
  int          req_cycles = 0;
  int          req_hi = 0, kbd_pulses = 0, dsp_pulses = 0;
  logic [15:0] addr_seen, wdata_seen;
  logic        we_seen, unstable;

  // Scoreboard monitor: compare on every rising ready
  initial begin
    logic rdy_prev;
    exp_t e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready && !rdy_prev) begin
        if (sb_q.size() == 0) check("unexpected_ready", {31'b0, ready}, 32'd0);
        else begin
          e = sb_q.pop_front();
          check({e.name, "_mdr"}, {16'b0, mdr_out}, {16'b0, e.mdr});
          check({e.name, "_err"}, {31'b0, mem_err}, {31'b0, e.err});
        end
      end
      rdy_prev = ready;
    end
  end

  // Memory model: ack the ack_after-th request cycle (0 = never ack)
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          req_cycles++;
          if (ack_after != 0 && req_cycles == ack_after) begin
            mem_ack = 1'b1;
            mem_rdata = rd_val;
          end
        end else req_cycles = 0;
      end
    end
  end

  // Bus watcher: request length, first-cycle snapshot, stability, pulses
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_hi++;
        if (req_hi == 1) begin
          addr_seen = mem_addr; we_seen = mem_we; wdata_seen = mem_wdata;
        end else if (mem_addr !== addr_seen || mem_we !== we_seen || mem_wdata !== wdata_seen)
          unstable = 1'b1;
      end
      if (kbd_ack) kbd_pulses++;
      if (dsp_valid) dsp_pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_mar = 1'b1; mar_in = a; ld_mdr = 1'b1; mdr_in = d;
    @(negedge clk);
    ld_mar = 1'b0; ld_mdr = 1'b0;
  endtask

  task automatic push(input string n, input logic [15:0] m, input logic e);
    exp_t x;
    x.name = n; x.mdr = m; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic start(input logic rw);
    req_hi = 0; unstable = 1'b0;
    r_w = rw; mio_en = 1'b1;
  endtask

  task automatic wait_ready(input string name, output int lat);
    lat = 0;
    while (!ready && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) check({name, "_ready_timeout"}, {31'b0, ready}, 32'd1);
  endtask

  task automatic drop();
    mio_en = 1'b0;
    @(negedge clk);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; ld_mar = 0; ld_mdr = 0; mar_in = '0; mdr_in = '0;
    mio_en = 0; r_w = 0; err_clr = 0;
    kbd_data = '0; kbd_valid = 0; dsp_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_mar",   {16'b0, mar_out},   32'h0);
    check("rst_mdr",   {16'b0, mdr_out},   32'h0);
    check("rst_ready", {31'b0, ready},     32'h0);
    check("rst_err",   {31'b0, mem_err},   32'h0);
    check("rst_req",   {31'b0, mem_req},   32'h0);
    check("rst_we",    {31'b0, mem_we},    32'h0);
    check("rst_addr",  {16'b0, mem_addr},  32'h0);
    check("rst_wdata", {16'b0, mem_wdata}, 32'h0);
    check("rst_mmio",  {22'b0, kbd_ack, dsp_valid, dsp_data}, 32'h0);
    rst_n = 1'b1;

    // Read, ack on third request cycle
    ack_after = 3; rd_val = 16'hABCD;
    load(16'h3000, 16'h0000);
    push("read", 16'hABCD, 1'b0);
    start(1'b0);
    wait_ready("read", lat);
    check("read_lat", lat, 32'd4);
    check("read_req_cycles", req_hi, 32'd3);
    check("read_we", {31'b0, we_seen}, 32'd0);
    check("read_addr", {16'b0, addr_seen}, 32'h3000);
    check("read_stable", {31'b0, unstable}, 32'd0);
    repeat (2) @(negedge clk);
    check("read_hold_ready", {31'b0, ready}, 32'd1);
    drop();
    check("read_ready_drop", {31'b0, ready}, 32'd0);

    // Write: MDR must keep the written value
    ack_after = 2; rd_val = 16'hDEAD;
    load(16'h4000, 16'h1234);
    push("write", 16'h1234, 1'b0);
    start(1'b1);
    wait_ready("write", lat);
    check("write_req_cycles", req_hi, 32'd2);
    check("write_we", {31'b0, we_seen}, 32'd1);
    check("write_addr", {16'b0, addr_seen}, 32'h4000);
    check("write_wdata", {16'b0, wdata_seen}, 32'h1234);
    check("write_stable", {31'b0, unstable}, 32'd0);
    drop();

    // Minimum latency: ack on first ACCESS cycle
    ack_after = 1; rd_val = 16'h0F0F;
    load(16'h5000, 16'h0000);
    push("lat2", 16'h0F0F, 1'b0);
    start(1'b0);
    wait_ready("lat2", lat);
    check("lat2_lat", lat, 32'd2);
    check("lat2_req_cycles", req_hi, 32'd1);
    drop();

    // Timeout after MAX_WAIT=4 cycles, then err_clr
    ack_after = 0;
    load(16'h6000, 16'h5555);
    push("timeout", 16'h0000, 1'b1);
    start(1'b0);
    wait_ready("timeout", lat);
    check("timeout_lat", lat, 32'd5);
    check("timeout_req_cycles", req_hi, 32'd4);
    drop();
    check("timeout_req_low", {31'b0, mem_req}, 32'd0);
    check("err_sticky", {31'b0, mem_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", {31'b0, mem_err}, 32'd0);

    // err_clr held across a timeout: set wins
    load(16'h6100, 16'h7777);
    push("err_race", 16'h0000, 1'b1);
    err_clr = 1'b1;
    start(1'b0);
    wait_ready("err_race", lat);
    err_clr = 1'b0;
    drop();
    check("err_race_hold", {31'b0, mem_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // ld_mar during ACCESS is ignored
    ack_after = 3; rd_val = 16'h2468;
    load(16'h7000, 16'h0000);
    push("ldmar_access", 16'h2468, 1'b0);
    start(1'b0);
    @(negedge clk);
    ld_mar = 1'b1; mar_in = 16'h7777;
    @(negedge clk);
    ld_mar = 1'b0;
    wait_ready("ldmar_access", lat);
    check("ldmar_access_addr", {16'b0, addr_seen}, 32'h7000);
    check("ldmar_access_stable", {31'b0, unstable}, 32'd0);
    check("ldmar_access_mar", {16'b0, mar_out}, 32'h7000);
    drop();

    // ld_mar together with mio_en: access uses the old MAR; ld_mdr in DONE
    ack_after = 1; rd_val = 16'h1111;
    load(16'h1100, 16'h0000);
    push("ldmar_start", 16'h1111, 1'b0);
    ld_mar = 1'b1; mar_in = 16'h2200;
    start(1'b0);
    @(negedge clk);
    ld_mar = 1'b0;
    wait_ready("ldmar_start", lat);
    check("ldmar_start_addr", {16'b0, addr_seen}, 32'h1100);
    check("ldmar_start_mar", {16'b0, mar_out}, 32'h2200);
    ld_mdr = 1'b1; mdr_in = 16'h9999;
    @(negedge clk);
    ld_mdr = 1'b0;
    check("ldmdr_done", {16'b0, mdr_out}, 32'h9999);
    drop();

    // mio_en dropped mid-access: still completes via DONE
    ack_after = 3; rd_val = 16'h3C3C;
    load(16'h8000, 16'h0000);
    push("drop_en", 16'h3C3C, 1'b0);
    start(1'b0);
    @(negedge clk);
    mio_en = 1'b0;
    wait_ready("drop_en", lat);
    @(negedge clk);
    check("drop_en_idle", {31'b0, ready}, 32'd0);

    // Stray mem_ack in IDLE is ignored
    resp_en = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_mdr", {16'b0, mdr_out}, 32'h3C3C);
    check("stray_ack_ready", {31'b0, ready}, 32'd0);
    resp_en = 1'b1;

`ifdef LC3_MMIO_EN
    kbd_valid = 1'b1; kbd_data = 8'h41; dsp_ready = 1'b1;
    kbd_pulses = 0;
    load(16'hFE00, 16'h0000);
    push("kbsr", 16'h8000, 1'b0);
    start(1'b0);
    wait_ready("kbsr", lat);
    check("kbsr_lat", lat, 32'd1);
    check("kbsr_no_req", req_hi, 32'd0);
    drop();
    load(16'hFE02, 16'h0000);
    push("kbdr", 16'h0041, 1'b0);
    start(1'b0);
    wait_ready("kbdr", lat);
    check("kbdr_no_req", req_hi, 32'd0);
    drop();
    check("kbd_ack_pulses", kbd_pulses, 32'd1);
    load(16'hFE04, 16'h0000);
    push("dsr", 16'h8000, 1'b0);
    start(1'b0);
    wait_ready("dsr", lat);
    drop();
    dsp_pulses = 0;
    load(16'hFE06, 16'h0058);
    push("ddr", 16'h0058, 1'b0);
    start(1'b1);
    wait_ready("ddr", lat);
    check("ddr_data", {24'b0, dsp_data}, 32'h58);
    drop();
    check("ddr_pulses", dsp_pulses, 32'd1);
    check("ddr_no_req", req_hi, 32'd0);
`else
    // Without MMIO decode, FE00 is ordinary memory
    kbd_pulses = 0; dsp_pulses = 0;
    ack_after = 1; rd_val = 16'h1357;
    load(16'hFE00, 16'h0000);
    push("fe00_mem", 16'h1357, 1'b0);
    start(1'b0);
    wait_ready("fe00_mem", lat);
    check("fe00_mem_req", req_hi, 32'd1);
    check("fe00_mem_addr", {16'b0, addr_seen}, 32'hFE00);
    drop();
    check("fe00_no_pulses", kbd_pulses + dsp_pulses, 32'd0);
`endif

    // Reset in the middle of an access
    ack_after = 0;
    load(16'h9000, 16'h4321);
    start(1'b0);
    repeat (2) @(negedge clk);
    check("midrst_req_pre", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_mar", {16'b0, mar_out}, 32'h0);
    check("midrst_mdr", {16'b0, mdr_out}, 32'h0);
    check("midrst_addr", {16'b0, mem_addr}, 32'h0);
    check("midrst_ready", {31'b0, ready}, 32'd0);
    mio_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_after = 1; rd_val = 16'h0A0A;
    load(16'h9100, 16'h0000);
    push("post_rst", 16'h0A0A, 1'b0);
    start(1'b0);
    wait_ready("post_rst", lat);
    check("post_rst_lat", lat, 32'd2);
    drop();

    @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
